// File: rtl/fwd_scoreboard_if.sv
// Operand-forwarding / hazard bundle between the ID stage and fwd_scoreboard.
// master = pipeline side driving stage and ID info, slave = the scoreboard.
interface fwd_scoreboard_if #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_READ   = 2,
  parameter int LAT_W      = 4,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
);
  logic [NUM_STAGES-1:0]     stage_we;
  logic [5*NUM_STAGES-1:0]   stage_rd;
  logic [NUM_STAGES-1:0]     stage_ready;
  logic                      id_valid;
  logic [5*NUM_READ-1:0]     id_rs;
  logic [NUM_READ-1:0]       id_rs_used;
  logic                      id_we;
  logic [4:0]                id_rd;
  logic                      id_mc;
  logic [LAT_W-1:0]          id_mc_lat;
  logic                      ext_stall;
  logic                      flush;
  logic [SEL_W*NUM_READ-1:0] fwd_sel;
  logic                      stall;
  logic                      issue;
  logic [31:0]               stall_cnt;

  modport master (
    output stage_we, stage_rd, stage_ready, id_valid, id_rs, id_rs_used,
           id_we, id_rd, id_mc, id_mc_lat, ext_stall, flush,
    input  fwd_sel, stall, issue, stall_cnt
  );

  modport slave (
    input  stage_we, stage_rd, stage_ready, id_valid, id_rs, id_rs_used,
           id_we, id_rd, id_mc, id_mc_lat, ext_stall, flush,
    output fwd_sel, stall, issue, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding selects, load-use / multi-cycle hazard stalls and a saturating stall counter for ID.
// fwd_sel/stall/issue are combinational (0 cycles); pending state is registered; ext_stall or flush only block issue.
module fwd_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_READ   = 2,
  parameter int LAT_W      = 4,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input logic            clk,
  input logic            rst_n,
  fwd_scoreboard_if.slave bus
);

  logic [LAT_W-1:0]          pend_cnt [1:31];
  logic [31:0]               pend;
  logic [31:0]               stall_cnt_q;
  logic [SEL_W*NUM_READ-1:0] sel_c;
  logic                      port_hit;
  logic                      port_rdy;
  logic [4:0]                port_rs;
  logic                      haz_nr;
  logic                      haz_pend;
  logic                      haz_waw;
  logic                      stall_c;
  logic                      issue_c;
  logic                      mc_wr;
  logic [LAT_W-1:0]          mc_load;

  always_comb begin
    pend[0] = 1'b0;
    for (int r = 1; r < 32; r++) begin
      pend[r] = (pend_cnt[r] != '0);
    end
  end

  // Scan oldest to youngest so the youngest matching stage is the last to win.
  always_comb begin
    sel_c    = '0;
    haz_nr   = 1'b0;
    haz_pend = 1'b0;
    port_hit = 1'b0;
    port_rdy = 1'b1;
    port_rs  = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      port_rs  = bus.id_rs[5*p +: 5];
      port_hit = 1'b0;
      port_rdy = 1'b1;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (bus.id_rs_used[p] && bus.stage_we[k] &&
            (bus.stage_rd[5*k +: 5] != 5'd0) &&
            (bus.stage_rd[5*k +: 5] == port_rs)) begin
          port_hit = 1'b1;
          port_rdy = bus.stage_ready[k];
          sel_c[SEL_W*p +: SEL_W] = SEL_W'(k + 1);
        end
      end
      if (port_hit && !port_rdy) begin
        haz_nr = 1'b1;
      end
      // A stage match is younger than any in-flight multi-cycle result.
      if (bus.id_rs_used[p] && !port_hit && pend[port_rs]) begin
        haz_pend = 1'b1;
      end
    end
  end

  assign haz_waw = bus.id_we && (bus.id_rd != 5'd0) && pend[bus.id_rd];
  assign stall_c = bus.id_valid && (haz_nr || haz_pend || haz_waw);
  assign issue_c = bus.id_valid && !stall_c && !bus.ext_stall && !bus.flush;
  assign mc_wr   = issue_c && bus.id_mc && bus.id_we && (bus.id_rd != 5'd0);

  // The count holds the remaining stall cycles: the result lands in the register
  // file on the L-th edge and is read through in that same cycle, so L-1 remain.
  assign mc_load = (bus.id_mc_lat > LAT_W'(1)) ? (bus.id_mc_lat - LAT_W'(1)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) begin
        pend_cnt[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (mc_wr && (bus.id_rd == 5'(r))) begin
          pend_cnt[r] <= mc_load;
        end else if (pend[r]) begin
          pend_cnt[r] <= pend_cnt[r] - LAT_W'(1);
        end
      end
      if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.fwd_sel   = sel_c;
  assign bus.stall     = stall_c;
  assign bus.issue     = issue_c;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scenario bench for fwd_scoreboard: expectations are queued when stimulus is
// driven and popped against the DUT outputs a moment later, away from the clock edge.
module tb_fwd_scoreboard;
  localparam int NS = 3;
  localparam int NR = 2;
  localparam int LW = 4;
  localparam int SW = 2;

  typedef struct {
    logic [SW*NR-1:0] sel;
    logic             stall;
    logic             issue;
    string            name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          n_tests;
  int          n_fail;
  logic [31:0] exp_cnt;
  exp_t        exp_q [$];

  fwd_scoreboard_if #(.NUM_STAGES(NS), .NUM_READ(NR), .LAT_W(LW), .SEL_W(SW)) bus ();

  fwd_scoreboard #(.NUM_STAGES(NS), .NUM_READ(NR), .LAT_W(LW), .SEL_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  function automatic logic [SW*NR-1:0] mk_sel(int s0, int s1);
    logic [1:0] a;
    logic [1:0] b;
    a = s0[1:0];
    b = s1[1:0];
    return {b, a};
  endfunction

  function automatic exp_t mk_exp(logic [SW*NR-1:0] sel, logic st, logic is, string nm);
    exp_t e;
    e.sel   = sel;
    e.stall = st;
    e.issue = is;
    e.name  = nm;
    return e;
  endfunction

  task automatic idle_inputs();
    bus.stage_we    = '0;
    bus.stage_rd    = '0;
    bus.stage_ready = '1;
    bus.id_valid    = 1'b0;
    bus.id_rs       = '0;
    bus.id_rs_used  = '0;
    bus.id_we       = 1'b0;
    bus.id_rd       = '0;
    bus.id_mc       = 1'b0;
    bus.id_mc_lat   = '0;
    bus.ext_stall   = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_stage(int k, int rd, bit rdy);
    bus.stage_we[k]         = 1'b1;
    bus.stage_rd[5*k +: 5]  = 5'(rd);
    bus.stage_ready[k]      = rdy;
  endtask

  task automatic set_read(int p, int rs, bit used);
    bus.id_rs[5*p +: 5] = 5'(rs);
    bus.id_rs_used[p]   = used;
  endtask

  task automatic set_id(int rd, bit we, bit mc, int lat);
    bus.id_valid  = 1'b1;
    bus.id_rd     = 5'(rd);
    bus.id_we     = we;
    bus.id_mc     = mc;
    bus.id_mc_lat = LW'(lat);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    @(negedge clk);
    idle_inputs();
    set_id(0, 1'b0, 1'b0, 0);
    set_read(0, 9, 1'b1);
    exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, "reset"));
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if ({bus.fwd_sel, bus.stall, bus.issue} !== {e.sel, e.stall, e.issue}) begin
      n_fail++;
      $display("FAIL %s: fwd_sel=%h stall=%b issue=%b, expected fwd_sel=%h stall=%b issue=%b",
               e.name, bus.fwd_sel, bus.stall, bus.issue, e.sel, e.stall, e.issue);
    end
    n_tests++;
    if (bus.stall_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, exp_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    exp_t     e;
    int       rd_t   [6][3];
    bit [2:0] rdy_t  [6];
    int       rs_t   [6][2];
    bit [1:0] used_t [6];
    int       s0_t   [6];
    int       s1_t   [6];
    rd_t   = '{'{-1, 5, 5}, '{-1, -1, 5}, '{5, 6, 6}, '{0, 5, -1}, '{-1, 5, -1}, '{8, 8, -1}};
    rdy_t  = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101};
    rs_t   = '{'{5, 0}, '{5, 6}, '{5, 6}, '{0, 5}, '{5, 5}, '{8, 0}};
    used_t = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01};
    s0_t   = '{2, 3, 1, 0, 0, 1};
    s1_t   = '{0, 0, 2, 2, 2, 0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      set_id(0, 1'b0, 1'b0, 0);
      for (int k = 0; k < NS; k++) begin
        if (rd_t[i][k] >= 0) set_stage(k, rd_t[i][k], rdy_t[i][k]);
      end
      for (int p = 0; p < NR; p++) set_read(p, rs_t[i][p], used_t[i][p]);
      exp_q.push_back(mk_exp(mk_sel(s0_t[i], s1_t[i]), 1'b0, 1'b1, $sformatf("fwd%0d", i)));
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue} !== {e.sel, e.stall, e.issue}) begin
        n_fail++;
        $display("FAIL %s: fwd_sel=%h stall=%b issue=%b, expected fwd_sel=%h stall=%b issue=%b",
                 e.name, bus.fwd_sel, bus.stall, bus.issue, e.sel, e.stall, e.issue);
      end
      n_tests++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, exp_cnt);
      end
      if (e.stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_inputs();
      set_id(0, 1'b0, 1'b0, 0);
      set_read(0, 3, 1'b1);
      set_read(1, 7, 1'b1);
      if (i == 0) begin
        set_stage(0, 7, 1'b0);
        exp_q.push_back(mk_exp(mk_sel(0, 1), 1'b1, 1'b0, "load_use_stall"));
      end else begin
        set_stage(1, 7, 1'b1);
        exp_q.push_back(mk_exp(mk_sel(0, 2), 1'b0, 1'b1, "load_use_fwd"));
      end
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue} !== {e.sel, e.stall, e.issue}) begin
        n_fail++;
        $display("FAIL %s: fwd_sel=%h stall=%b issue=%b, expected fwd_sel=%h stall=%b issue=%b",
                 e.name, bus.fwd_sel, bus.stall, bus.issue, e.sel, e.stall, e.issue);
      end
      n_tests++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, exp_cnt);
      end
      if (e.stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    end
  endtask

  // waw=0: dependent reads the mc destination; waw=1: dependent overwrites it.
  task automatic test_mc_dep(int lat, bit waw);
    exp_t e;
    int   nstall;
    nstall = (lat <= 1) ? 0 : lat - 1;
    for (int i = 0; i < nstall + 2; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        set_id(9, 1'b1, 1'b1, lat);
        exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, $sformatf("mc_issue_lat%0d", lat)));
      end else begin
        if (waw) set_id(9, 1'b1, 1'b0, 0);
        else begin
          set_id(0, 1'b0, 1'b0, 0);
          set_read(0, 9, 1'b1);
        end
        exp_q.push_back(mk_exp(mk_sel(0, 0), (i <= nstall), (i > nstall),
                               $sformatf("%s_lat%0d_c%0d", waw ? "waw" : "raw", lat, i)));
      end
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue} !== {e.sel, e.stall, e.issue}) begin
        n_fail++;
        $display("FAIL %s: fwd_sel=%h stall=%b issue=%b, expected fwd_sel=%h stall=%b issue=%b",
                 e.name, bus.fwd_sel, bus.stall, bus.issue, e.sel, e.stall, e.issue);
      end
      n_tests++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, exp_cnt);
      end
      if (e.stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    end
  endtask

  task automatic test_x0_and_block();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle_inputs();
      case (i)
        0: begin
          set_id(0, 1'b1, 1'b1, 6);
          exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, "mc_x0_issue"));
        end
        1: begin
          set_id(0, 1'b1, 1'b0, 0);
          set_read(0, 0, 1'b1);
          exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, "x0_no_hazard"));
        end
        2: begin
          set_id(12, 1'b1, 1'b1, 5);
          bus.flush = 1'b1;
          exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b0, "flush_mc"));
        end
        3: begin
          set_id(0, 1'b0, 1'b0, 0);
          set_read(1, 12, 1'b1);
          exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, "after_flush"));
        end
        4: begin
          set_id(13, 1'b1, 1'b1, 5);
          bus.ext_stall = 1'b1;
          exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b0, "ext_stall_mc"));
        end
        5: begin
          set_id(13, 1'b1, 1'b0, 0);
          set_read(0, 13, 1'b1);
          exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, "after_ext_stall"));
        end
        default: begin
          set_id(0, 1'b0, 1'b0, 0);
          set_stage(0, 7, 1'b0);
          set_read(0, 7, 1'b1);
          bus.ext_stall = 1'b1;
          exp_q.push_back(mk_exp(mk_sel(1, 0), 1'b1, 1'b0, "hazard_with_ext"));
        end
      endcase
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue} !== {e.sel, e.stall, e.issue}) begin
        n_fail++;
        $display("FAIL %s: fwd_sel=%h stall=%b issue=%b, expected fwd_sel=%h stall=%b issue=%b",
                 e.name, bus.fwd_sel, bus.stall, bus.issue, e.sel, e.stall, e.issue);
      end
      n_tests++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, exp_cnt);
      end
      if (e.stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   nsteps;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      set_id(9 + i, 1'b1, 1'b1, 15);
      exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, $sformatf("rst_fill_x%0d", 9 + i)));
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue} !== {e.sel, e.stall, e.issue}) begin
        n_fail++;
        $display("FAIL %s: fwd_sel=%h stall=%b issue=%b, expected fwd_sel=%h stall=%b issue=%b",
                 e.name, bus.fwd_sel, bus.stall, bus.issue, e.sel, e.stall, e.issue);
      end
    end
    // Build the stall count up to 10, then hit reset mid-cycle with x9 still pending.
    nsteps = 0;
    while (nsteps < 20) begin
      @(negedge clk);
      idle_inputs();
      set_id(0, 1'b0, 1'b0, 0);
      set_read(0, 9, 1'b1);
      exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b1, 1'b0, $sformatf("rst_pre_%0d", nsteps)));
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue, bus.stall_cnt} !== {e.sel, e.stall, e.issue, exp_cnt}) begin
        n_fail++;
        $display("FAIL %s: stall=%b issue=%b stall_cnt=%0d, expected stall=%b issue=%b stall_cnt=%0d",
                 e.name, bus.stall, bus.issue, bus.stall_cnt, e.stall, e.issue, exp_cnt);
      end
      if (exp_cnt >= 32'd10) break;
      exp_cnt++;
      nsteps++;
    end
    #1;
    rst_n = 1'b0;
    exp_cnt = '0;
    exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, "rst_async"));
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if ({bus.fwd_sel, bus.stall, bus.issue, bus.stall_cnt} !== {e.sel, e.stall, e.issue, exp_cnt}) begin
      n_fail++;
      $display("FAIL %s: stall=%b issue=%b stall_cnt=%0d, expected stall=%b issue=%b stall_cnt=%0d",
               e.name, bus.stall, bus.issue, bus.stall_cnt, e.stall, e.issue, exp_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      if (i == 2) set_id(11, 1'b1, 1'b0, 0);
      else begin
        set_id(0, 1'b0, 1'b0, 0);
        set_read(1, 10 + i, 1'b1);
      end
      exp_q.push_back(mk_exp(mk_sel(0, 0), 1'b0, 1'b1, $sformatf("rst_after_%0d", i)));
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue, bus.stall_cnt} !== {e.sel, e.stall, e.issue, exp_cnt}) begin
        n_fail++;
        $display("FAIL %s: stall=%b issue=%b stall_cnt=%0d, expected stall=%b issue=%b stall_cnt=%0d",
                 e.name, bus.stall, bus.issue, bus.stall_cnt, e.stall, e.issue, exp_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      idle_inputs();
      set_id(0, 1'b0, 1'b0, 0);
      set_stage(0, 7, 1'b0);
      set_read(0, 7, 1'b1);
      exp_q.push_back(mk_exp(mk_sel(1, 0), 1'b1, 1'b0, $sformatf("saturate_%0d", i)));
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.fwd_sel, bus.stall, bus.issue} !== {e.sel, e.stall, e.issue}) begin
        n_fail++;
        $display("FAIL %s: fwd_sel=%h stall=%b issue=%b, expected fwd_sel=%h stall=%b issue=%b",
                 e.name, bus.fwd_sel, bus.stall, bus.issue, e.sel, e.stall, e.issue);
      end
      n_tests++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %h expected %h", e.name, bus.stall_cnt, exp_cnt);
      end
      if (e.stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = '0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_mc_dep(4, 1'b0);
    test_mc_dep(1, 1'b0);
    test_mc_dep(0, 1'b0);
    test_mc_dep(5, 1'b1);
    test_x0_and_block();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
